pwm_level_decoder: RTL and testbench
====================================

// Module: pwm_level_decoder
// PURPOSE
//   Receive side of the 16-step LED PWM scheme: recovers the 4-bit brightness level from one
//   PWM line driven by a free-running pulse-counter encoder (high while pulse < f). Window
//   counting needs no phase alignment to the encoder. A confirm filter rejects one-window
//   glitches. Output feeds brightness/position logic, or a loopback check of the LED driver.
// PARAMETERS
//   PERIOD        16  encoder PWM period in clocks; must be 2**CNT_BITS
//   CNT_BITS      4   width of level output, log2(PERIOD)
//   CONFIRM       2   consecutive equal windows required to accept a new level (>=1)
//   LOSS_WINDOWS  4   windows spent in CHANGE without confirming before lock is dropped
// PORTS
//   oneMHzClock   in   1         single system clock, all logic on posedge
//   reset_n       in   1         asynchronous, active-low reset
//   pwm_in        in   1         PWM line, asynchronous to oneMHzClock
//   level         out  CNT_BITS  accepted duty: high clocks per period, clamped to PERIOD-1
//   level_strobe  out  1         one-cycle pulse when level is (re)loaded
//   full_on       out  1         accepted window had all PERIOD samples high
//   locked        out  1         a level has been confirmed and is being tracked
// BEHAVIOUR
//   Reset (async, reset_n=0): sync flops, wcnt, hcnt, cand, match, lossc = 0; state=ACQUIRE;
//     level=0, level_strobe=0, full_on=0, locked=0. Takes effect mid-window, no partial result.
//   Input: 2-flop synchronizer -> s. pwm_in to s latency = 2 clocks.
//   Window: wcnt free-runs 0..PERIOD-1 and wraps. hcnt (CNT_BITS+1 bits) counts s==1.
//     At wcnt==PERIOD-1: sample = hcnt + s (range 0..PERIOD), then hcnt <= 0. Window end = WE.
//   Confirm filter at each WE: if sample==cand, match <= min(match+1, CONFIRM);
//     else cand <= sample, match <= 1. conf = new match value == CONFIRM.
//   Accept: level <= min(cand_new, PERIOD-1); full_on <= (cand_new==PERIOD);
//     level_strobe=1 for the clock after WE, 0 otherwise.
//   FSM, evaluated only at WE:
//     ACQUIRE: locked=0. conf -> accept, LOCKED.
//     LOCKED : locked=1. sample==accepted value -> stay.
//              sample differs -> CHANGE, lossc <= 1.
//     CHANGE : locked=1, level held.
//              sample==held value -> LOCKED, no strobe.
//              conf on new value -> accept, LOCKED.
//              else lossc++; lossc reaches LOSS_WINDOWS -> ACQUIRE, locked <= 0 (level held).
//   Re-accepting an unchanged value never strobes. Outputs are registered and change only
//     on the clock after WE.
//   Pulse input with period != PERIOD: sample is a window average; the filter rejects jitter.
// TESTING (PERIOD=16, CONFIRM=2, LOSS_WINDOWS=4)
//   1 pwm_in=0 from reset release -> strobe once at end of window 2 (clk 32), level=0, locked=1
//   2 duty 3/16 at each phase offset 0..15 -> level=3 for every offset, full_on=0
//   3 pwm_in=1 constant -> level=15, full_on=1, locked=1
//   4 locked at 15, step to duty 1/16 -> locked stays 1; level=1 + one strobe by end of 3rd WE
//   5 duty 3 stream with one 7/16 window inserted -> no strobe, level stays 3, locked stays 1
//   6 locked at 3, new duty every window (5,9,12,6) -> locked=0 after 4th WE, level=3;
//     reset_n=0 mid-window -> all outputs 0 immediately

Source files
------------

// File: rtl/pwm_level_decoder.sv
// rtl/pwm_level_decoder.sv - recovers the PWM brightness level by counting high samples per window
// A level is accepted only after CONFIRM equal windows; lock drops after LOSS_WINDOWS unresolved windows.
`timescale 1ns/1ps
module pwm_level_decoder #(
  parameter int PERIOD       = 16,
  parameter int CNT_BITS     = 4,
  parameter int CONFIRM      = 2,
  parameter int LOSS_WINDOWS = 4
) (
  input  logic                oneMHzClock,
  input  logic                reset_n,
  input  logic                pwm_in,
  output logic [CNT_BITS-1:0] level,
  output logic                level_strobe,
  output logic                full_on,
  output logic                locked
);

  localparam int MW = $clog2(CONFIRM + 1);
  localparam int LW = $clog2(LOSS_WINDOWS + 1);

  localparam logic [MW-1:0]       MATCH_MAX = MW'(CONFIRM);
  localparam logic [LW-1:0]       LOSS_MAX  = LW'(LOSS_WINDOWS);
  localparam logic [CNT_BITS:0]   FULL_CNT  = (CNT_BITS + 1)'(PERIOD);
  localparam logic [CNT_BITS-1:0] WCNT_LAST = CNT_BITS'(PERIOD - 1);

  localparam logic [1:0] ST_ACQUIRE = 2'd0;
  localparam logic [1:0] ST_LOCKED  = 2'd1;
  localparam logic [1:0] ST_CHANGE  = 2'd2;

  logic                sync1_q, sync1_d;
  logic                sync2_q, sync2_d;
  logic [CNT_BITS-1:0] wcnt_q, wcnt_d;
  logic [CNT_BITS:0]   hcnt_q, hcnt_d;
  logic [CNT_BITS:0]   cand_q, cand_d;
  logic [MW-1:0]       match_q, match_d;
  logic [LW-1:0]       lossc_q, lossc_d;
  logic [1:0]          state_q, state_d;
  logic [CNT_BITS:0]   acc_q, acc_d;
  logic                acc_vld_q, acc_vld_d;
  logic [CNT_BITS-1:0] level_q, level_d;
  logic                strobe_q, strobe_d;
  logic                full_on_q, full_on_d;
  logic                locked_q, locked_d;

  logic              we;
  logic [CNT_BITS:0] sample;
  logic              conf;
  logic              accept;

  always_comb begin
    sync1_d   = pwm_in;
    sync2_d   = sync1_q;
    wcnt_d    = wcnt_q + 1'b1;
    we        = (wcnt_q == WCNT_LAST);
    // The sample of the last clock is folded in so a window covers exactly PERIOD samples.
    sample    = hcnt_q + {{CNT_BITS{1'b0}}, sync2_q};
    hcnt_d    = we ? '0 : sample;
    cand_d    = cand_q;
    match_d   = match_q;
    lossc_d   = lossc_q;
    state_d   = state_q;
    acc_d     = acc_q;
    acc_vld_d = acc_vld_q;
    level_d   = level_q;
    full_on_d = full_on_q;
    locked_d  = locked_q;
    strobe_d  = 1'b0;
    conf      = 1'b0;
    accept    = 1'b0;

    if (we) begin
      if (sample == cand_q) begin
        if (match_q != MATCH_MAX) begin
          match_d = match_q + 1'b1;
        end
      end else begin
        cand_d  = sample;
        match_d = MW'(1);
      end
      conf = (match_d == MATCH_MAX);

      case (state_q)
        ST_ACQUIRE: begin
          if (conf) begin
            accept = 1'b1;
          end
        end
        ST_LOCKED: begin
          if (sample != acc_q) begin
            state_d = ST_CHANGE;
            lossc_d = LW'(1);
          end
        end
        ST_CHANGE: begin
          if (sample == acc_q) begin
            state_d = ST_LOCKED;
          end else if (conf) begin
            accept = 1'b1;
          end else begin
            lossc_d = lossc_q + 1'b1;
            if (lossc_d >= LOSS_MAX) begin
              state_d = ST_ACQUIRE;
              lossc_d = '0;
            end
          end
        end
        default: begin
          state_d = ST_ACQUIRE;
        end
      endcase

      // Reloading the value already held keeps the strobe quiet.
      if (accept) begin
        state_d   = ST_LOCKED;
        acc_d     = cand_d;
        acc_vld_d = 1'b1;
        strobe_d  = !acc_vld_q || (cand_d != acc_q);
        level_d   = (cand_d >= FULL_CNT) ? {CNT_BITS{1'b1}} : cand_d[CNT_BITS-1:0];
        full_on_d = (cand_d == FULL_CNT);
      end
      locked_d = (state_d != ST_ACQUIRE);
    end
  end

  always_ff @(posedge oneMHzClock or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      wcnt_q    <= '0;
      hcnt_q    <= '0;
      cand_q    <= '0;
      match_q   <= '0;
      lossc_q   <= '0;
      state_q   <= ST_ACQUIRE;
      acc_q     <= '0;
      acc_vld_q <= 1'b0;
      level_q   <= '0;
      strobe_q  <= 1'b0;
      full_on_q <= 1'b0;
      locked_q  <= 1'b0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      wcnt_q    <= wcnt_d;
      hcnt_q    <= hcnt_d;
      cand_q    <= cand_d;
      match_q   <= match_d;
      lossc_q   <= lossc_d;
      state_q   <= state_d;
      acc_q     <= acc_d;
      acc_vld_q <= acc_vld_d;
      level_q   <= level_d;
      strobe_q  <= strobe_d;
      full_on_q <= full_on_d;
      locked_q  <= locked_d;
    end
  end

  assign level        = level_q;
  assign level_strobe = strobe_q;
  assign full_on      = full_on_q;
  assign locked       = locked_q;

endmodule

// File: tb/tb_pwm_level_decoder.sv
// tb/tb_pwm_level_decoder.sv - scoreboard bench for pwm_level_decoder
// Expected outputs come from window sums of the driven line and the accept/loss rules.
`timescale 1ns/1ps
module tb_pwm_level_decoder;
  localparam int PERIOD       = 16;
  localparam int CNT_BITS     = 4;
  localparam int CONFIRM      = 2;
  localparam int LOSS_WINDOWS = 4;
  localparam int PIN_DEPTH    = 4096;

  typedef struct {
    int level;
    int full;
    int locked;
    int strobe;
  } exp_t;

  logic                clk    = 1'b0;
  logic                rst_n  = 1'b0;
  logic                pwm_in = 1'b0;
  logic [CNT_BITS-1:0] level;
  logic                level_strobe;
  logic                full_on;
  logic                locked;

  pwm_level_decoder #(
    .PERIOD(PERIOD), .CNT_BITS(CNT_BITS), .CONFIRM(CONFIRM), .LOSS_WINDOWS(LOSS_WINDOWS)
  ) dut (
    .oneMHzClock(clk), .reset_n(rst_n), .pwm_in(pwm_in),
    .level(level), .level_strobe(level_strobe), .full_on(full_on), .locked(locked)
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc;
  int   strobe_cnt;
  bit   pin [0:PIN_DEPTH-1];
  int   hist[$];
  exp_t sbq[$];
  exp_t cur;
  bit   m_trk, m_chg, m_accv;
  int   m_acc, m_level, m_full, m_lossc;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d, t=%0t)", nm, act, exp, cyc, $time);
    end
  endtask

  function automatic bit pat(int n, int duty, int off);
    return ((n + off) % PERIOD) < duty;
  endfunction

  task automatic model_clear();
    foreach (pin[i]) pin[i] = 1'b0;
    hist.delete();
    sbq.delete();
    cur        = '{0, 0, 0, 0};
    m_trk      = 1'b0;
    m_chg      = 1'b0;
    m_accv     = 1'b0;
    m_acc      = 0;
    m_level    = 0;
    m_full     = 0;
    m_lossc    = 0;
    strobe_cnt = 0;
  endtask

  // Window w sees the line as driven at clocks 16w-17 .. 16w-2 (two-flop synchronizer lag).
  task automatic model_window(int w);
    int   smp = 0;
    bit   conf;
    bit   take = 1'b0;
    exp_t e;
    for (int k = PERIOD * w - PERIOD - 1; k <= PERIOD * w - 2; k++)
      if (k >= 1) smp += int'(pin[k]);
    hist.push_back(smp);
    if (hist.size() > CONFIRM) void'(hist.pop_front());
    conf = (hist.size() == CONFIRM);
    foreach (hist[i]) if (hist[i] != smp) conf = 1'b0;
    e.strobe = 0;
    if (!m_trk) begin
      take = conf;
    end else if (!m_chg) begin
      if (smp != m_acc) begin
        m_chg   = 1'b1;
        m_lossc = 1;
      end
    end else if (smp == m_acc) begin
      m_chg = 1'b0;
    end else if (conf) begin
      take = 1'b1;
    end else begin
      m_lossc++;
      if (m_lossc >= LOSS_WINDOWS) begin
        m_trk = 1'b0;
        m_chg = 1'b0;
      end
    end
    if (take) begin
      e.strobe = (!m_accv || smp != m_acc) ? 1 : 0;
      m_acc    = smp;
      m_accv   = 1'b1;
      m_trk    = 1'b1;
      m_chg    = 1'b0;
      m_level  = (smp > PERIOD - 1) ? PERIOD - 1 : smp;
      m_full   = (smp == PERIOD) ? 1 : 0;
    end
    e.level  = m_level;
    e.full   = m_full;
    e.locked = m_trk ? 1 : 0;
    sbq.push_back(e);
  endtask

  task automatic drive(bit v);
    int n = cyc + 1;
    if (n >= PIN_DEPTH) begin
      $display("FAIL pin_depth: stimulus index %0d exceeds %0d", n, PIN_DEPTH);
      $fatal(1);
    end
    pwm_in = v;
    pin[n] = v;
    if ((n + 2) % PERIOD == 0) model_window((n + 2) / PERIOD);
    @(posedge clk);
    #1;
  endtask

  task automatic drive_pat(int ncyc, int duty, int off);
    for (int i = 0; i < ncyc; i++) drive(pat(cyc + 1, duty, off));
  endtask

  task automatic align(int duty, int off);
    while (cyc % PERIOD != PERIOD - 2) drive(pat(cyc + 1, duty, off));
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (cyc > 0 && cyc % PERIOD == 0) begin
          if (sbq.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL sb_empty: no expected entry at cycle %0d", cyc);
          end else begin
            cur = sbq.pop_front();
            check("we_level", level, cur.level);
            check("we_full_on", full_on, cur.full);
            check("we_locked", locked, cur.locked);
            check("we_strobe", level_strobe, cur.strobe);
          end
          cur.strobe = 0;
        end else begin
          check("hold_level", level, cur.level);
          check("hold_full_on", full_on, cur.full);
          check("hold_locked", locked, cur.locked);
          check("idle_strobe", level_strobe, 0);
        end
        if (level_strobe) strobe_cnt++;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int   offs[PERIOD];
    int   j, tmp, base, off, duty, cnt, we_seen;
    int   t6[4];
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    check("reset_level", level, 0);
    check("reset_strobe", level_strobe, 0);
    check("reset_full_on", full_on, 0);
    check("reset_locked", locked, 0);
    rst_n = 1'b1;

    drive_pat(PERIOD, 0, 0);
    check("t1_unlocked_we1", locked, 0);
    drive_pat(PERIOD, 0, 0);
    check("t1_strobe_clk32", level_strobe, 1);
    check("t1_level", level, 0);
    check("t1_locked", locked, 1);
    drive_pat(PERIOD, 0, 0);
    check("t1_one_strobe", strobe_cnt, 1);

    foreach (offs[i]) offs[i] = i;
    for (int i = PERIOD - 1; i > 0; i--) begin
      j       = $urandom_range(0, i);
      tmp     = offs[i];
      offs[i] = offs[j];
      offs[j] = tmp;
    end
    for (int i = 0; i < PERIOD; i++) begin
      drive_pat(4 * PERIOD, 3, offs[i]);
      check("t2_level", level, 3);
      check("t2_full_on", full_on, 0);
      check("t2_locked", locked, 1);
    end

    drive_pat(5 * PERIOD, PERIOD, 0);
    check("t3_level", level, 15);
    check("t3_full_on", full_on, 1);
    check("t3_locked", locked, 1);

    drive_pat($urandom_range(0, PERIOD - 1), PERIOD, 0);
    off     = $urandom_range(0, PERIOD - 1);
    base    = strobe_cnt;
    we_seen = 0;
    while (we_seen < 3) begin
      drive(pat(cyc + 1, 1, off));
      if (cyc % PERIOD == 0) begin
        we_seen++;
        check("t4_locked_we", locked, 1);
      end
    end
    check("t4_level", level, 1);
    check("t4_full_on", full_on, 0);
    drive(pat(cyc + 1, 1, off));
    check("t4_one_strobe", strobe_cnt - base, 1);

    align(1, off);
    off = $urandom_range(0, PERIOD - 1);
    drive_pat(3 * PERIOD, 3, off);
    base = strobe_cnt;
    drive_pat(PERIOD, 7, off);
    drive_pat(3 * PERIOD + 3, 3, off);
    check("t5_no_strobe", strobe_cnt - base, 0);
    check("t5_level", level, 3);
    check("t5_locked", locked, 1);

    align(3, off);
    t6 = '{5, 9, 12, 6};
    foreach (t6[i]) begin
      off = $urandom_range(0, PERIOD - 1);
      drive_pat(PERIOD, t6[i], off);
    end
    drive_pat(2, 6, off);
    check("t6_unlocked", locked, 0);
    check("t6_level_held", level, 3);
    drive_pat($urandom_range(1, 12), 6, off);
    rst_n = 1'b0;
    #1;
    check("t6_rst_level", level, 0);
    check("t6_rst_strobe", level_strobe, 0);
    check("t6_rst_full_on", full_on, 0);
    check("t6_rst_locked", locked, 0);
    repeat (2) @(posedge clk);
    #1;
    model_clear();
    rst_n = 1'b1;

    duty = 3;
    off  = 0;
    for (int i = 0; i < 140; i++) begin
      cnt = $urandom_range(8, 24);
      case ($urandom_range(0, 9))
        0:       for (int k = 0; k < cnt; k++) drive(bit'($urandom_range(0, 1)));
        1, 2:    begin duty = $urandom_range(0, PERIOD); drive_pat(cnt, duty, off); end
        3:       begin off = $urandom_range(0, PERIOD - 1); drive_pat(cnt, duty, off); end
        default: drive_pat(cnt, duty, off);
      endcase
    end
    while (cyc % PERIOD != 0) drive(pat(cyc + 1, duty, off));
    @(negedge clk);
    #1;
    check("sb_drained", sbq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
